// File: rtl/yin_tau_sweep_ctrl.sv
// yin_tau_sweep_ctrl: walks one diff_module over tau = 1..MAX_TAU for a single
// analysis window, keeps a running sum of d(tau), and applies the YIN
// cumulative-mean-normalized threshold test by cross-multiplication:
//   d(tau) / ((1/tau) * sum) < threshold  <=>  d*tau*2^TH_FRAC < threshold*sum
// The first tau that passes wins; otherwise the smallest d(tau) (tau >= MIN_TAU)
// is reported as a fallback.
//
// Handshake with diff_module: diff_reset high restarts its accumulation; it
// drops diff_ready whenever it samples diff_reset high and raises diff_ready
// (with diff_acc valid) once the window sum for diff_tau is complete. The
// controller holds diff_reset low for the whole WAIT, so a stale ready from
// the previous tau can never be seen.
module yin_tau_sweep_ctrl #(
    parameter int ACC_WIDTH      = 39,
    parameter int TAU_BITS       = 6,
    parameter int MAX_TAU        = 40,
    parameter int MIN_TAU        = 2,
    parameter int TH_FRAC        = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [TH_FRAC:0]     threshold,
    output logic [TAU_BITS-1:0]  diff_tau,
    output logic                 diff_reset,
    input  logic                 diff_ready,
    input  logic [ACC_WIDTH-1:0] diff_acc,
    output logic                 result_valid,
    output logic [TAU_BITS-1:0]  result_tau,
    output logic [ACC_WIDTH-1:0] result_value,
    output logic                 busy,
    output logic                 done,
    output logic [TAU_BITS-1:0]  best_tau,
    output logic                 best_found,
    output logic                 error
);

    localparam int SUM_W  = ACC_WIDTH + TAU_BITS;
    localparam int PROD_W = SUM_W + TH_FRAC + 1;
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0]    TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TAU_BITS-1:0] TAU_MIN_C  = TAU_BITS'(MIN_TAU);
    localparam logic [TAU_BITS-1:0] TAU_MAX_C  = TAU_BITS'(MAX_TAU);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_EVAL,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [TAU_BITS-1:0]  tau_q;
    logic [SUM_W-1:0]     sum_q;
    logic [ACC_WIDTH-1:0] d_q;
    logic [ACC_WIDTH-1:0] min_q;
    logic [TAU_BITS-1:0]  min_tau_q;
    logic [TH_FRAC:0]     th_q;
    logic [TMR_W-1:0]     timer_q;

    logic [SUM_W-1:0]  sum_next;
    logic [PROD_W-1:0] lhs;
    logic [PROD_W-1:0] rhs;
    logic              eligible;
    logic              hit;
    logic              min_upd;
    logic              last_tau;
    logic              timeout_hit;

    // Threshold test and minimum tracking for the tau currently in EVAL.
    always_comb begin
        sum_next    = sum_q + SUM_W'(d_q);
        lhs         = (PROD_W'(d_q) * PROD_W'(tau_q)) << TH_FRAC;
        rhs         = PROD_W'(th_q) * PROD_W'(sum_next);
        eligible    = (tau_q >= TAU_MIN_C);
        hit         = eligible && (sum_next != '0) && (lhs < rhs);
        min_upd     = eligible && (d_q < min_q);
        last_tau    = (tau_q == TAU_MAX_C);
        timeout_hit = (timer_q == TMR_LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d      = state_q;
        diff_reset   = 1'b1;
        busy         = 1'b0;
        done         = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                busy    = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                busy       = 1'b1;
                diff_reset = 1'b0;
                if (diff_ready)       state_d = S_EVAL;
                else if (timeout_hit) state_d = S_DONE;
            end
            S_EVAL: begin
                busy         = 1'b1;
                diff_reset   = 1'b0;
                result_valid = 1'b1;
                if (hit || last_tau) state_d = S_DONE;
                else                 state_d = S_ISSUE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sweep datapath: tau, running sum, captured d, minimum, timer, results.
    always_ff @(posedge clk) begin
        if (reset) begin
            tau_q      <= '0;
            sum_q      <= '0;
            d_q        <= '0;
            min_q      <= '0;
            min_tau_q  <= '0;
            th_q       <= '0;
            timer_q    <= '0;
            best_tau   <= '0;
            best_found <= 1'b0;
            error      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        th_q       <= threshold;
                        tau_q      <= TAU_BITS'(1);
                        sum_q      <= '0;
                        min_q      <= '1;
                        min_tau_q  <= TAU_MIN_C;
                        best_tau   <= '0;
                        best_found <= 1'b0;
                        error      <= 1'b0;
                    end
                end
                S_ISSUE: timer_q <= '0;
                S_WAIT: begin
                    if (diff_ready)       d_q     <= diff_acc;
                    else if (timeout_hit) error   <= 1'b1;
                    else                  timer_q <= timer_q + 1'b1;
                end
                S_EVAL: begin
                    sum_q <= sum_next;
                    if (hit) begin
                        best_tau   <= tau_q;
                        best_found <= 1'b1;
                    end else begin
                        if (min_upd) begin
                            min_q     <= d_q;
                            min_tau_q <= tau_q;
                        end
                        if (last_tau) begin
                            best_tau   <= min_upd ? tau_q : min_tau_q;
                            best_found <= 1'b0;
                        end else begin
                            tau_q <= tau_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff_tau     = tau_q;
    assign result_tau   = tau_q;
    assign result_value = d_q;

endmodule

// File: tb/tb_yin_tau_sweep_ctrl.sv
// Bench for yin_tau_sweep_ctrl: a table-driven diff_module stub, a sweep-level
// reference model (plain arithmetic over the d(tau) table), a per-cycle compare
// process, directed scenarios and randomized sweeps.
module tb_yin_tau_sweep_ctrl;

  localparam int ACC_WIDTH      = 39;
  localparam int TAU_BITS       = 6;
  localparam int MAX_TAU        = 40;
  localparam int MIN_TAU        = 2;
  localparam int TH_FRAC        = 8;
  localparam int TIMEOUT_CYCLES = 4096;
  localparam int EW             = TAU_BITS + ACC_WIDTH;

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic [TH_FRAC:0]     threshold;
  logic [TAU_BITS-1:0]  diff_tau;
  logic                 diff_reset;
  logic                 diff_ready;
  logic [ACC_WIDTH-1:0] diff_acc;
  logic                 result_valid;
  logic [TAU_BITS-1:0]  result_tau;
  logic [ACC_WIDTH-1:0] result_value;
  logic                 busy;
  logic                 done;
  logic [TAU_BITS-1:0]  best_tau;
  logic                 best_found;
  logic                 error;

  yin_tau_sweep_ctrl #(
    .ACC_WIDTH(ACC_WIDTH), .TAU_BITS(TAU_BITS), .MAX_TAU(MAX_TAU),
    .MIN_TAU(MIN_TAU), .TH_FRAC(TH_FRAC), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .threshold(threshold),
    .diff_tau(diff_tau), .diff_reset(diff_reset), .diff_ready(diff_ready),
    .diff_acc(diff_acc), .result_valid(result_valid), .result_tau(result_tau),
    .result_value(result_value), .busy(busy), .done(done),
    .best_tau(best_tau), .best_found(best_found), .error(error)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  int  exp_best;
  int  exp_found;
  int  exp_err;
  int  done_cnt;
  int  wait_cnt;
  bit  prev_issue;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- diff_module stub ----------------
  logic [ACC_WIDTH-1:0] tab [0:63];
  int stub_lat;
  bit stub_never;
  int stub_cnt;

  always @(posedge clk) begin
    if (diff_reset || stub_never) begin
      stub_cnt   <= 0;
      diff_ready <= 1'b0;
    end else if (stub_cnt >= stub_lat) begin
      diff_ready <= 1'b1;
    end else begin
      stub_cnt <= stub_cnt + 1;
    end
  end
  assign diff_acc = tab[diff_tau];

  // ---------------- reference model ----------------
  // Expected per-tau results and final selection, straight from the YIN rules.
  task automatic model(input logic [TH_FRAC:0] th);
    longint unsigned sum, mn, d, t;
    int mt;
    sum = 0;
    mn  = (64'd1 << ACC_WIDTH) - 1;
    mt  = MIN_TAU;
    exp_q.delete();
    exp_best  = 0;
    exp_found = 0;
    exp_err   = 0;
    for (int i = 1; i <= MAX_TAU; i++) begin
      t = longint'(i);
      d = 64'(tab[i]);
      sum += d;
      exp_q.push_back({TAU_BITS'(i), tab[i]});
      if (i >= MIN_TAU && sum != 0 && (d * t * 256) < (64'(th) * sum)) begin
        exp_best  = i;
        exp_found = 1;
        return;
      end
      if (i >= MIN_TAU && d < mn) begin
        mn = d;
        mt = i;
      end
      if (i == MAX_TAU) exp_best = mt;
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!reset) begin
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual_tau=%0d expected=none", result_tau);
        end else begin
          e = exp_q.pop_front();
          chk("result_tau", 64'(result_tau), 64'(e[EW-1:ACC_WIDTH]));
          chk("result_value", 64'(result_value), 64'(e[ACC_WIDTH-1:0]));
          chk("diff_tau_in_eval", 64'(diff_tau), 64'(e[EW-1:ACC_WIDTH]));
        end
      end
      if (done) done_cnt++;
      if (busy && !diff_reset && !result_valid) wait_cnt++;
      if (busy && diff_reset) chk("diff_reset_one_cycle", 64'(prev_issue), 64'd0);
      prev_issue = busy && diff_reset;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_const(input logic [ACC_WIDTH-1:0] v);
    for (int i = 0; i < 64; i++) tab[i] = (i >= 1 && i <= MAX_TAU) ? v : '0;
  endtask

  task automatic start_sweep(input logic [TH_FRAC:0] th);
    done_cnt = 0;
    wait_cnt = 0;
    @(negedge clk);
    start     = 1'b1;
    threshold = th;
    @(negedge clk);
    start     = 1'b0;
    threshold = 9'($urandom_range(0, 511));
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("best_tau_cleared", 64'(best_tau), 64'd0);
    chk("best_found_cleared", 64'(best_found), 64'd0);
    chk("error_cleared", 64'(error), 64'd0);
  endtask

  task automatic finish_sweep(input int poke_tau, input bit start_in_done, input int budget);
    bit seen, poked;
    seen  = 0;
    poked = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (poke_tau != 0 && !poked && busy && diff_tau == TAU_BITS'(poke_tau)) begin
        start     = 1'b1;
        threshold = 9'd511;
        poked     = 1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("done_within_budget", 64'(seen), 64'd1);
    chk("best_tau", 64'(best_tau), 64'(exp_best));
    chk("best_found", 64'(best_found), 64'(exp_found));
    chk("error", 64'(error), 64'(exp_err));
    chk("busy_in_done", 64'(busy), 64'd0);
    chk("results_consumed", 64'(exp_q.size()), 64'd0);
    if (start_in_done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_in_done_ignored", 64'(busy), 64'd0);
    end else begin
      @(negedge clk);
    end
    @(negedge clk);
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("best_tau_held", 64'(best_tau), 64'(exp_best));
    exp_q.delete();
  endtask

  task automatic run_sweep(input logic [TH_FRAC:0] th, input int lat, input bit never,
                           input int poke_tau, input bit start_in_done, input int budget);
    stub_lat   = lat;
    stub_never = never;
    if (never) begin
      exp_q.delete();
      exp_best  = 0;
      exp_found = 0;
      exp_err   = 1;
    end else begin
      model(th);
    end
    start_sweep(th);
    finish_sweep(poke_tau, start_in_done, budget);
    stub_never = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    int mode, k;
    reset      = 1'b1;
    start      = 1'b0;
    threshold  = '0;
    stub_lat   = 0;
    stub_never = 0;
    prev_issue = 0;
    done_cnt   = 0;
    wait_cnt   = 0;
    fill_const('0);
    repeat (3) @(negedge clk);
    chk("rst_diff_reset", 64'(diff_reset), 64'd1);
    chk("rst_diff_tau", 64'(diff_tau), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result_valid", 64'(result_valid), 64'd0);
    chk("rst_best_tau", 64'(best_tau), 64'd0);
    chk("rst_best_found", 64'(best_found), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Early threshold hit at tau 4; start during DONE must be ignored.
    fill_const('0);
    tab[1] = 1000; tab[2] = 1000; tab[3] = 1000; tab[4] = 40;
    model(9'd26);
    chk("pin_t1_best", 64'(exp_best), 64'd4);
    chk("pin_t1_found", 64'(exp_found), 64'd1);
    chk("pin_t1_count", 64'(exp_q.size()), 64'd4);
    run_sweep(9'd26, 300, 0, 0, 1, 2000);

    // Fallback minimum at tau 7 over the full sweep.
    fill_const(39'd500);
    tab[7] = 100;
    model(9'd26);
    chk("pin_t2_best", 64'(exp_best), 64'd7);
    chk("pin_t2_found", 64'(exp_found), 64'd0);
    chk("pin_t2_count", 64'(exp_q.size()), 64'd40);
    run_sweep(9'd26, 6, 0, 0, 0, 2000);

    // Silent input: no hit, tie keeps the lowest eligible tau.
    fill_const('0);
    model(9'd26);
    chk("pin_t3_best", 64'(exp_best), 64'd2);
    run_sweep(9'd26, 2, 0, 0, 0, 1000);

    // Timeout on tau 1.
    run_sweep(9'd26, 0, 1, 0, 0, TIMEOUT_CYCLES + 100);
    chk("timeout_wait_cycles", 64'(wait_cnt), 64'(TIMEOUT_CYCLES));

    // Reset during WAIT at tau 5, then a clean restart.
    fill_const(39'd500);
    stub_lat = 5;
    model(9'd26);
    start_sweep(9'd26);
    found = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (busy && !diff_reset && !result_valid && diff_tau == 6'd5) begin
        found = 1;
        break;
      end
    end
    chk("reached_wait_tau5", 64'(found), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_diff_reset", 64'(diff_reset), 64'd1);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_diff_tau", 64'(diff_tau), 64'd0);
    reset = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    fill_const(39'd100);
    model(9'd26);
    chk("pin_t5_best", 64'(exp_best), 64'd2);
    chk("pin_t5_found", 64'(exp_found), 64'd0);
    run_sweep(9'd26, 3, 0, 0, 0, 1000);

    // Second start while busy at tau 10 is ignored.
    fill_const(39'd500);
    run_sweep(9'd26, 4, 0, 10, 0, 1000);

    // Randomized sweeps.
    for (int r = 0; r < 20; r++) begin
      mode = $urandom_range(0, 2);
      for (int i = 0; i < 64; i++) tab[i] = '0;
      for (int i = 1; i <= MAX_TAU; i++) begin
        case (mode)
          0:       tab[i] = 39'({$urandom, $urandom});
          1:       tab[i] = 39'($urandom_range(500, 3000));
          default: tab[i] = 39'($urandom_range(0, 3));
        endcase
      end
      if (mode == 1) begin
        k = $urandom_range(2, MAX_TAU);
        tab[k] = 39'($urandom_range(0, 200));
      end
      run_sweep(9'($urandom_range(0, 511)), $urandom_range(0, 8), 0, 0,
                1'($urandom_range(0, 1)), 1000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
